infer_seq_ctrl: RTL

Sequencer between the host byte link (UART debug core) and the ML model's byte-wide input/output buffers. Each inference runs the same sequence:
- accepts exactly N_IN bytes from the host and writes them into the model input buffer;
- pulses the model start;
- waits for the model to report results ready, with a timeout;
- drains exactly N_OUT result bytes back to the host.

It replaces ad-hoc wiring of host put/req strobes directly onto the model.

---
 rtl/infer_seq_pkg.sv | 20 ++
 rtl/seq_timeout_ctr.sv | 36 +++
 rtl/infer_seq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/infer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : infer_seq_pkg
// Brief    : Shared types and constants for the inference sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package infer_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_ctr
// Brief    : Cycle counter with clear, enable and expiry on TIMEOUT_CYCLES-1.
// Revision : 1.0 - initial release
// ============================================================================
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Expiry is only meaningful while counting; the owner leaves WAIT on it.
  assign o_expire = i_en & (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/infer_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : infer_seq_ctrl
// Brief    : Host-link to ML-buffer sequencer: load, start, wait, drain.
// Revision : 1.0 - initial release
// ============================================================================
module infer_seq_ctrl
  import infer_seq_pkg::*;
#(
  parameter int N_IN           = 16,
  parameter int N_OUT          = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  output logic [BYTE_W-1:0] host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  output logic [BYTE_W-1:0] ml_in_data,
  output logic              ml_in_wr,
  input  logic              ml_in_full,
  output logic              ml_start,
  input  logic              ml_out_valid,
  input  logic [BYTE_W-1:0] ml_out_data,
  output logic              ml_out_rd,
  output logic              busy,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  inf_count
);

  localparam int IN_W  = $clog2(N_IN + 1);
  localparam int OUT_W = $clog2(N_OUT + 1);
  localparam logic [IN_W-1:0]  c_in_last  = IN_W'(N_IN - 1);
  localparam logic [OUT_W-1:0] c_out_last = OUT_W'(N_OUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IN_W-1:0]  r_in_cnt;
  logic [OUT_W-1:0] r_out_cnt;
  logic             r_cap;
  logic             w_rx_fire;
  logic             w_tx_fire;
  logic             w_rd_issue;
  logic             w_drain_done;
  logic             w_timed_out;
  logic             w_tmo_load;
  logic             w_tmo_en;
  logic             w_tmo_expire;

  assign host_rx_ready = (r_state == LOAD) & ~ml_in_full;
  assign w_rx_fire     = host_rx_valid & host_rx_ready;
  assign w_tx_fire     = host_tx_valid & host_tx_ready;
  assign w_tmo_load    = (r_state == START);
  assign w_tmo_en      = (r_state == WAIT) & ~ml_out_valid;

  seq_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmo_load),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_issue   = 1'b0;
    w_drain_done = 1'b0;
    w_timed_out  = 1'b0;
    case (r_state)
      IDLE:  if (host_rx_valid) w_state_next = LOAD;
      LOAD:  if (w_rx_fire && (r_in_cnt == c_in_last)) w_state_next = START;
      START: w_state_next = WAIT;
      WAIT: begin
        if (ml_out_valid) begin
          w_state_next = DRAIN;
        end else if (w_tmo_expire) begin
          w_timed_out  = 1'b1;
          w_state_next = IDLE;
        end
      end
      DRAIN: begin
        if (w_tx_fire && (r_out_cnt == c_out_last)) begin
          w_drain_done = 1'b1;
          w_state_next = IDLE;
        end else begin
          // Slot is free once no read is in flight and the holding register empties this edge.
          w_rd_issue = ~ml_out_rd & ~r_cap & (~host_tx_valid | w_tx_fire);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_cap         <= 1'b0;
      ml_in_data    <= '0;
      ml_in_wr      <= 1'b0;
      ml_start      <= 1'b0;
      ml_out_rd     <= 1'b0;
      host_tx_data  <= '0;
      host_tx_valid <= 1'b0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      inf_count     <= '0;
    end else begin
      ml_in_wr  <= w_rx_fire;
      ml_start  <= (r_state == START);
      ml_out_rd <= w_rd_issue;
      r_cap     <= ml_out_rd;
      busy      <= (w_state_next != IDLE);

      if (w_rx_fire) ml_in_data <= host_rx_data;

      if ((r_state == IDLE) && (w_state_next == LOAD)) begin
        r_in_cnt    <= '0;
        err_timeout <= 1'b0;
      end else if (w_rx_fire) begin
        r_in_cnt <= r_in_cnt + IN_W'(1);
      end

      if ((r_state == WAIT) && (w_state_next == DRAIN)) begin
        r_out_cnt <= '0;
      end else if (w_tx_fire) begin
        r_out_cnt <= r_out_cnt + OUT_W'(1);
      end

      if (w_timed_out) err_timeout <= 1'b1;
      if (w_drain_done) inf_count <= inf_count + CNT_W'(1);

      // Model data is valid the cycle after the read strobe.
      if (r_cap) begin
        host_tx_data  <= ml_out_data;
        host_tx_valid <= 1'b1;
      end else if (w_tx_fire) begin
        host_tx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
